// File: rtl/dsa_pkg.sv
// -----------------------------------------------------------------------------
// dsa_pkg
// Shared definitions for the bilinear-scaling DSA run controller:
//   - run_state_e : run controller state encoding
//   - MODE_SEQ / MODE_SIMD4 : core select values
//   - CFG_W : width of each configuration field
//   - cfg_valid() : configuration sanity check used at accept time
// -----------------------------------------------------------------------------
package dsa_pkg;

  localparam int CFG_W = 16;

  localparam logic MODE_SEQ   = 1'b0;
  localparam logic MODE_SIMD4 = 1'b1;

  typedef enum logic [2:0] {
    RST_CLEAR = 3'd0,
    IDLE      = 3'd1,
    CLEAR     = 3'd2,
    ARM       = 3'd3,
    RUN       = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } run_state_e;

  // A run is legal when the image is non-empty, the scale is non-zero and the
  // output image fits in mem_out. The product is formed at 32 bits so that
  // 16x16-bit operands cannot wrap.
  function automatic logic cfg_valid(
    input logic [CFG_W-1:0] w,
    input logic [CFG_W-1:0] h,
    input logic [CFG_W-1:0] scale,
    input logic [31:0]      max_pix
  );
    logic [31:0] prod;
    prod = 32'(w) * 32'(h);
    return (w != {CFG_W{1'b0}}) && (h != {CFG_W{1'b0}}) &&
           (scale != {CFG_W{1'b0}}) && (prod <= max_pix);
  endfunction

endpackage

// File: rtl/mem_clear_sweeper.sv
// -----------------------------------------------------------------------------
// mem_clear_sweeper
// Walks every mem_out address once, writing zero, after a go pulse.
// Ports:
//   clk_50 : system clock
//   rst_n  : asynchronous active-low reset
//   go     : (re)start the sweep at address 0 on the next edge
//   we     : write enable, high for 2^AW consecutive cycles
//   addr   : address being cleared, 0 .. 2^AW-1
//   last   : high in the cycle that writes the top address
// All outputs are decodes of local registers only.
// -----------------------------------------------------------------------------
module mem_clear_sweeper #(
  parameter int AW = 12
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          go,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

  logic          active_r;
  logic [AW-1:0] addr_r;

  // Sweep engine: go starts at address 0, then one address per cycle to the top.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      addr_r   <= ADDR_ZERO;
    end else if (go) begin
      active_r <= 1'b1;
      addr_r   <= ADDR_ZERO;
    end else if (active_r) begin
      if (addr_r == ADDR_MAX) begin
        active_r <= 1'b0;
        addr_r   <= ADDR_ZERO;
      end else begin
        active_r <= 1'b1;
        addr_r   <= addr_r + AW'(1);
      end
    end else begin
      active_r <= 1'b0;
      addr_r   <= addr_r;
    end
  end

  assign we   = active_r;
  assign addr = addr_r;
  assign last = active_r && (addr_r == ADDR_MAX);

endmodule

// File: rtl/dsa_run_ctrl.sv
// -----------------------------------------------------------------------------
// dsa_run_ctrl
// Run controller for the bilinear-scaling DSA. Per run it latches and checks
// the configuration, clears mem_out, fires a one-cycle start at the selected
// core and times the run against a watchdog.
// Ports:
//   clk_50, rst_n                    : clock, asynchronous active-low reset
//   start_req                        : start pulse from the debounced switch
//   mode_simd_req                    : core select request (0 SEQ, 1 SIMD4)
//   in_w_cfg, in_h_cfg, scale_q88_cfg: raw configuration
//   in_w_lat, in_h_lat, scale_lat    : configuration captured at accept
//   mode_simd_eff                    : core select captured at accept
//   clr_we, clr_addr, clear_active   : mem_out clear port (data is zero)
//   start_seq, start_simd            : one-cycle core start pulses
//   done_seq, done_simd              : core completion (pulse or level)
//   busy, done                       : status (CLEAR/ARM/RUN, DONE)
//   cfg_err, timeout_err             : sticky until the next accepted start
//   run_cycles                       : RUN cycles of the last run
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module dsa_run_ctrl
  import dsa_pkg::*;
#(
  parameter int AW          = 12,
  parameter int CW          = 32,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             start_req,
  input  logic             mode_simd_req,
  input  logic [CFG_W-1:0] in_w_cfg,
  input  logic [CFG_W-1:0] in_h_cfg,
  input  logic [CFG_W-1:0] scale_q88_cfg,
  output logic [CFG_W-1:0] in_w_lat,
  output logic [CFG_W-1:0] in_h_lat,
  output logic [CFG_W-1:0] scale_lat,
  output logic             mode_simd_eff,
  output logic             clr_we,
  output logic [AW-1:0]    clr_addr,
  output logic             clear_active,
  output logic             start_seq,
  output logic             start_simd,
  input  logic             done_seq,
  input  logic             done_simd,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             timeout_err,
  output logic [CW-1:0]    run_cycles
);

  localparam logic [31:0]   MAX_PIX   = 32'd1 << AW;
  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT_CYC);

  run_state_e       state_r;
  run_state_e       state_s;

  logic [CFG_W-1:0] in_w_r;
  logic [CFG_W-1:0] in_h_r;
  logic [CFG_W-1:0] scale_r;
  logic             mode_r;

  logic             busy_r;
  logic             done_r;
  logic             start_seq_r;
  logic             start_simd_r;
  logic             cfg_err_r;
  logic             timeout_err_r;
  logic [CW-1:0]    run_cycles_r;

  logic             accept_s;
  logic             cfg_ok_s;
  logic             done_sel_s;
  logic             timeout_hit_s;
  logic             sweep_go_s;
  logic             sweep_we_s;
  logic [AW-1:0]    sweep_addr_s;
  logic             sweep_last_s;

  // Starts are only taken when the controller is at rest.
  assign accept_s = start_req &&
                    ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));

  // The check is applied to the values being captured on this very edge, so
  // the verdict is known in the accept cycle and an illegal run never starts
  // a clear sweep.
  assign cfg_ok_s = cfg_valid(in_w_cfg, in_h_cfg, scale_q88_cfg, MAX_PIX);

  // Only the core that was actually started is listened to.
  assign done_sel_s    = (mode_r == MODE_SIMD4) ? done_simd : done_seq;
  assign timeout_hit_s = (run_cycles_r == TIMEOUT_V);

  // Power-up sweep kicks off once the sweeper is idle in RST_CLEAR; a run
  // sweep is kicked off by a legal accept.
  assign sweep_go_s = ((state_r == RST_CLEAR) && !sweep_we_s) ||
                      (accept_s && cfg_ok_s);

  mem_clear_sweeper #(
    .AW (AW)
  ) u_sweeper (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .go     (sweep_go_s),
    .we     (sweep_we_s),
    .addr   (sweep_addr_s),
    .last   (sweep_last_s)
  );

  // State register.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_CLEAR;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RST_CLEAR: begin
        if (sweep_last_s) state_s = IDLE;
        else              state_s = RST_CLEAR;
      end
      IDLE, DONE, ERR: begin
        if (accept_s) begin
          if (cfg_ok_s) state_s = CLEAR;
          else          state_s = ERR;
        end else begin
          state_s = state_r;
        end
      end
      CLEAR: begin
        if (sweep_last_s) state_s = ARM;
        else              state_s = CLEAR;
      end
      ARM: begin
        state_s = RUN;
      end
      RUN: begin
        // A completion in the same cycle as the watchdog expiry counts as done.
        if (done_sel_s)         state_s = DONE;
        else if (timeout_hit_s) state_s = ERR;
        else                    state_s = RUN;
      end
      default: begin
        state_s = RST_CLEAR;
      end
    endcase
  end

  // Status and start pulses, registered from the next state.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      start_seq_r  <= 1'b0;
      start_simd_r <= 1'b0;
    end else begin
      busy_r       <= (state_s == CLEAR) || (state_s == ARM) || (state_s == RUN);
      done_r       <= (state_s == DONE);
      start_seq_r  <= (state_r == CLEAR) && (state_s == ARM) && (mode_r == MODE_SEQ);
      start_simd_r <= (state_r == CLEAR) && (state_s == ARM) && (mode_r == MODE_SIMD4);
    end
  end

  // Configuration capture; held for the whole run regardless of the inputs.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      in_w_r  <= {CFG_W{1'b0}};
      in_h_r  <= {CFG_W{1'b0}};
      scale_r <= {CFG_W{1'b0}};
      mode_r  <= MODE_SEQ;
    end else if (accept_s) begin
      in_w_r  <= in_w_cfg;
      in_h_r  <= in_h_cfg;
      scale_r <= scale_q88_cfg;
      mode_r  <= mode_simd_req;
    end else begin
      in_w_r  <= in_w_r;
      in_h_r  <= in_h_r;
      scale_r <= scale_r;
      mode_r  <= mode_r;
    end
  end

  // Error flags and cycle counter; cleared on accept, otherwise sticky/held.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      run_cycles_r  <= {CW{1'b0}};
    end else if (accept_s) begin
      cfg_err_r     <= !cfg_ok_s;
      timeout_err_r <= 1'b0;
      run_cycles_r  <= {CW{1'b0}};
    end else begin
      cfg_err_r <= cfg_err_r;
      // The count advances on entry to RUN and on every RUN cycle that stays
      // in RUN, so it reads k during the k-th RUN cycle and then holds.
      if ((state_r == ARM) || ((state_r == RUN) && (state_s == RUN))) begin
        run_cycles_r <= run_cycles_r + CW'(1);
      end else begin
        run_cycles_r <= run_cycles_r;
      end
      if ((state_r == RUN) && (state_s == ERR)) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  assign in_w_lat      = in_w_r;
  assign in_h_lat      = in_h_r;
  assign scale_lat     = scale_r;
  assign mode_simd_eff = mode_r;
  assign clr_we        = sweep_we_s;
  assign clr_addr      = sweep_addr_s;
  assign clear_active  = sweep_we_s;
  assign start_seq     = start_seq_r;
  assign start_simd    = start_simd_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign cfg_err       = cfg_err_r;
  assign timeout_err   = timeout_err_r;
  assign run_cycles    = run_cycles_r;

endmodule
